// File: rtl/ppu_bg_pkg.sv
// Shared background/attribute definitions: FSM states, attribute-table
// constants and the tile-to-attribute-field locator used by the read and write paths.
package ppu_bg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WRITE
  } state_t;

  localparam logic [15:0] ATTR_OFFSET  = 16'h03C0;
  localparam logic [15:0] MAX_TILE_OFF = 16'h03BF;

  typedef struct packed {
    logic [15:0] attr_addr;
    logic [2:0]  shift;
    logic        in_range;
  } attr_loc_t;

  function automatic attr_loc_t attr_locate(input logic [15:0] base,
                                            input logic [15:0] tile,
                                            input logic [15:0] attr_offset);
    logic [15:0] off;
    attr_loc_t   loc;
    off = tile - base;
    // row = off[9:5], col = off[4:0]; each attribute byte covers a 4x4 tile block
    loc.attr_addr = base + attr_offset + {10'd0, off[9:7], 3'b000} + {13'd0, off[4:2]};
    loc.shift     = {off[6], off[1], 1'b0};
    loc.in_range  = (off <= MAX_TILE_OFF);
    return loc;
  endfunction

endpackage

// File: rtl/attr_addr_calc.sv
// Combinational mapping from a nametable tile address to its attribute byte
// address, 2-bit field position and a legality flag.
module attr_addr_calc
  import ppu_bg_pkg::*;
#(
  parameter logic [15:0] ATTR_OFFSET = ppu_bg_pkg::ATTR_OFFSET
) (
  input  logic [15:0] base_addr,
  input  logic [15:0] tile_addr,
  output logic [15:0] attr_addr,
  output logic [2:0]  shift,
  output logic        in_range
);

  attr_loc_t loc;

  always_comb loc = attr_locate(base_addr, tile_addr, ATTR_OFFSET);

  assign attr_addr = loc.attr_addr;
  assign shift     = loc.shift;
  assign in_range  = loc.in_range;

endmodule

// File: rtl/attr_rmw_writer.sv
// Stores a 2-bit palette select for one background tile by read-modify-write
// of its attribute byte, leaving the other three fields untouched.
module attr_rmw_writer
  import ppu_bg_pkg::*;
#(
  parameter int          RD_LATENCY  = 2,
  parameter logic [15:0] ATTR_OFFSET = ppu_bg_pkg::ATTR_OFFSET
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_base_addr,
  input  logic [15:0] req_tile_addr,
  input  logic [1:0]  req_palette,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rd_data,
  output logic        mem_wr_en,
  output logic [7:0]  mem_wr_data,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] WAIT_LOAD = 3'(RD_LATENCY - 1);

  state_t      state, state_next;
  logic [15:0] attr_addr;
  logic [2:0]  shift;
  logic        in_range;
  logic [15:0] addr_q;
  logic [2:0]  shift_q;
  logic [1:0]  palette_q;
  logic [2:0]  wait_cnt;
  logic [7:0]  wr_data_q;
  logic        err_q;
  logic [7:0]  field_mask;
  logic [7:0]  field_val;
  logic [7:0]  merged;

  attr_addr_calc #(
    .ATTR_OFFSET(ATTR_OFFSET)
  ) u_calc (
    .base_addr(req_base_addr),
    .tile_addr(req_tile_addr),
    .attr_addr(attr_addr),
    .shift    (shift),
    .in_range (in_range)
  );

  assign field_mask = 8'h03 << shift_q;
  assign field_val  = {6'b0, palette_q} << shift_q;
  assign merged     = (mem_rd_data & ~field_mask) | field_val;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && in_range) state_next = RD_REQ;
      end
      RD_REQ: begin
        mem_rd_en  = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_cnt == 3'd0) state_next = WRITE;
      end
      WRITE: begin
        mem_wr_en  = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, read-latency countdown and merge of the returned byte
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= 16'h0000;
      shift_q   <= 3'd0;
      palette_q <= 2'd0;
      wait_cnt  <= 3'd0;
      wr_data_q <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (in_range) begin
              addr_q    <= attr_addr;
              shift_q   <= shift;
              palette_q <= req_palette;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RD_REQ:  wait_cnt <= WAIT_LOAD;
        RD_WAIT: begin
          if (wait_cnt == 3'd0) wr_data_q <= merged;
          else                  wait_cnt  <= wait_cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wr_data = wr_data_q;
  assign err         = err_q;

endmodule

// File: doc/attr_rmw_writer.md
Name: attr_rmw_writer

Overview:
- Writes a 2-bit palette select for one background tile into its attribute-table byte. This is the write-side counterpart of the nametable-to-attribute lookup.
- Takes a nametable tile address and a palette value, then computes the attribute byte address and 2-bit field position.
- Performs a read-modify-write on PPU VRAM so the other three fields of the byte are preserved.
- Used by the background/VRAM update path when software or the test harness assigns palettes per tile.

Parameters:
- RD_LATENCY, 2, cycles from the mem_rd_en pulse to valid mem_rd_data (legal range 1..7).
- ATTR_OFFSET, 16'h03C0, offset of the attribute table from the nametable base.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept.
- req_base_addr  in  16  nametable base address (e.g. 16'h2000).
- req_tile_addr  in  16  nametable tile address.
- req_palette  in  2  palette select to store.
- mem_addr  out  16  VRAM address.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_rd_data  in  8  read data, valid exactly RD_LATENCY cycles after mem_rd_en.
- mem_wr_en  out  1  one-cycle write strobe.
- mem_wr_data  out  8  write data.
- done  out  1  one-cycle pulse when the write is issued.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (synchronous, active-high) forces state IDLE.
- Output values in reset: req_ready=1, mem_rd_en=0, mem_wr_en=0, done=0, err=0, mem_addr=0, mem_wr_data=0.
- Handshake: a request is accepted on a clk edge where req_valid && req_ready. All request inputs are registered at acceptance and ignored afterwards.
- Arithmetic, all unsigned 16-bit, wrap on overflow:
  - off = tile − base.
  - row = off[9:5], col = off[4:0].
  - attr_addr = base + ATTR_OFFSET + {row[4:2],3'b000} + col[4:2].
  - shift = {row[1], col[1], 1'b0}, giving 0, 2, 4 or 6.
- Range check: if off > 16'h03BF, no memory access is made. Next cycle: err=1, state returns to IDLE, req_ready=1.
- States:
  - IDLE: req_ready=1. On accept with a legal offset, go to RD_REQ.
  - RD_REQ: mem_addr=attr_addr, mem_rd_en=1 for one cycle, load wait counter, go to RD_WAIT.
  - RD_WAIT: hold mem_addr; count RD_LATENCY cycles. On the cycle mem_rd_data is valid, capture it and go to WRITE.
  - WRITE: mem_addr=attr_addr, mem_wr_en=1, mem_wr_data = (rd & ~(8'h03<<shift)) | (palette<<shift), done=1; go to IDLE.
- Latency: from the accept edge to the write strobe is 2+RD_LATENCY cycles. req_ready is deasserted from the cycle after acceptance until the cycle after WRITE.
- mem_rd_en and mem_wr_en are never asserted in the same cycle.
- Outside RD_REQ and WRITE, both strobes are 0; mem_addr holds its last value.
- Reset mid-operation: abandon the transaction with no write issued; a pending read return is ignored.
- Back-to-back requests: a new request may be accepted in the cycle IDLE is re-entered, with no bubble beyond the WRITE cycle.
- Writing a palette equal to the current field value still issues the write, with data unchanged.

Decomposition:
- Shared package ppu_bg_pkg:
  - state encoding (IDLE, RD_REQ, RD_WAIT, WRITE);
  - ATTR_OFFSET, MAX_TILE_OFF=16'h03BF;
  - the function computing attr_addr/shift.
- One natural sub-module, attr_addr_calc: combinational off/row/col/attr_addr/shift/in_range. The same sub-module is shared with the read path.

Test Plan:
- Basic field 0: base=2000, tile=2000, pal=3, rd returns 00 -> rd at 23C0, write 23C0 data 03, done pulse at accept+2+RD_LATENCY.
- Field 6 clear: tile=2042 (row2, col2), pal=0, rd FF -> addr 23C0, shift 6, write 3F.
- Corner tile with mixed field: tile=23BF (row29, col31), pal=2, rd A5 -> addr 23FF, shift 2, write A9.
- Range error: tile=23C0 -> err pulse next cycle, no mem_rd_en/mem_wr_en ever, req_ready back to 1.
- Reset in RD_WAIT: assert rst one cycle after mem_rd_en -> no mem_wr_en, outputs at reset values, a subsequent request completes normally.
- Back-to-back with different bases: base=2400 tile=2400 pal=1 then base=2C00 tile=2C21 pal=2 with req_valid held -> writes to 27C0 then 2FC0, second accepted right after the first done, each field correct.
